// File: rtl/mod_msg_sched.sv
// SHA-256 message-schedule generator: 16 words in, W[0..63] out with round index.
// Latency 1 cycle in->out; output register stalls (and IN_READY drops) while W_READY is low.
`timescale 1ns/1ps
module mod_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] word_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] w_out,
    output logic [5:0]  t_out,
    output logic        w_last,
    output logic        w_valid,
    input  logic        w_ready,
    output logic        busy
);
    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    state_t      state, state_nxt;
    logic [5:0]  t;
    logic [31:0] msg_buf [16];

    logic        free, load_fire, gen_fire;
    logic [3:0]  idx, i14, i9, i1;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign free      = !w_valid || w_ready;
    assign load_fire = in_valid && in_ready;
    // t wraps to 0 after W[63] is loaded; that marks the generator as finished.
    assign gen_fire  = (state == EXPAND) && free && (t != 6'd0);

    assign idx   = t[3:0];
    assign i14   = idx + 4'd14;
    assign i9    = idx + 4'd9;
    assign i1    = idx + 4'd1;
    assign w_new = sig1(msg_buf[i14]) + msg_buf[i9] + sig0(msg_buf[i1]) + msg_buf[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (load_fire && t == 6'd15) state_nxt = EXPAND;
            EXPAND:  if (w_valid && w_ready && w_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD) && free;
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t       <= '0;
            w_out   <= '0;
            t_out   <= '0;
            w_last  <= 1'b0;
            w_valid <= 1'b0;
            for (int i = 0; i < 16; i++) msg_buf[i] <= '0;
        end else begin
            if (state == IDLE && start) t <= '0;
            if (load_fire) begin
                msg_buf[idx] <= word_in;
                w_out        <= word_in;
                t_out        <= t;
                w_last       <= 1'b0;
                w_valid      <= 1'b1;
                t            <= t + 6'd1;
            end else if (gen_fire) begin
                msg_buf[idx] <= w_new;
                w_out        <= w_new;
                t_out        <= t;
                w_last       <= (t == LAST_T);
                w_valid      <= 1'b1;
                t            <= t + 6'd1;
            end else if (free) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mod_msg_sched.sv
// Bench for mod_msg_sched: schedule model from the SHA-256 recurrence, checked on every transfer.
`timescale 1ns/1ps
module tb_mod_msg_sched;
    typedef logic [31:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] word_in = '0;
    logic        in_valid = 1'b0;
    logic        w_ready = 1'b1;
    logic        in_ready, w_last, w_valid, busy;
    logic [31:0] w_out;
    logic [5:0]  t_out;

    mod_msg_sched #(.ROUNDS(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_in(word_in),
        .in_valid(in_valid), .in_ready(in_ready), .w_out(w_out), .t_out(t_out),
        .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_w [64];
    int          exp_idx = 64;
    bit          mon_en = 1'b0;
    bit          rand_rdy = 1'b0;
    int          cyc = 0;
    int          first_cyc = 0, last_cyc = 0, start_cyc = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_w;
    logic [5:0]  stall_t;
    blk_t        abc, zero, blk2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input blk_t blk);
        for (int k = 0; k < 16; k++) exp_w[k] = blk[k];
        for (int k = 16; k < 64; k++)
            exp_w[k] = s1(exp_w[k-2]) + exp_w[k-7] + s0(exp_w[k-15]) + exp_w[k-16];
        exp_idx = 0;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        w_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Compare process: every transfer against the model, every stall for stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else if (mon_en) begin
            if (stall_prev)
                check("stall_hold", {w_valid, t_out, w_out}, {1'b1, stall_t, stall_w});
            if (w_valid && w_ready) begin
                if (exp_idx > 63) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got t_out=%0d w_out=0x%0h, required no transfer", t_out, w_out);
                end else begin
                    check($sformatf("w_out[%0d]", exp_idx), w_out, exp_w[exp_idx]);
                    check($sformatf("t_out[%0d]", exp_idx), t_out, exp_idx);
                    check($sformatf("w_last[%0d]", exp_idx), w_last, (exp_idx == 63));
                    if (exp_idx == 0)  first_cyc = cyc;
                    if (exp_idx == 63) last_cyc  = cyc;
                    exp_idx++;
                end
            end
            stall_prev = w_valid && !w_ready;
            stall_w    = w_out;
            stall_t    = t_out;
        end
    end

    task automatic run_block(input blk_t blk, input bit gaps, input bit pulses,
                             input bit start_at_end, input int abort_at);
        int  g;
        bit  acc;
        build_model(blk);
        mon_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        g = 0;
        for (int i = 0; i < 16 && g < 500; g++) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            word_in  = blk[i];
            start    = pulses && (i == 5);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        g = 0;
        while (exp_idx < 64 && !(abort_at > 0 && exp_idx >= abort_at) && g < 3000) begin
            start = (pulses && exp_idx == 40) || (start_at_end && w_valid && w_last);
            @(posedge clk); #1;
            g++;
        end
        start = 1'b0;
        if (abort_at > 0) begin
            check("abort_reached", exp_idx >= abort_at, 1'b1);
            rst_n = 1'b0;
            #1;
            check("rst_w_valid", w_valid, 1'b0);
            check("rst_w_out", w_out, 32'h0);
            check("rst_t_out", t_out, 6'd0);
            check("rst_busy_inready", {busy, in_ready, w_last}, 3'b000);
            exp_idx = 64;
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            check("post_rst_idle", {w_valid, busy}, 2'b00);
        end else begin
            check("schedule_count", exp_idx, 64);
            check("busy_after_last", busy, 1'b0);
            check("idle_outputs", {w_valid, in_ready}, 2'b00);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            abc[k]  = '0;
            zero[k] = '0;
            blk2[k] = 32'h9E3779B9 * (k + 1) ^ 32'h0F1E2D3C;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        repeat (3) @(posedge clk);
        #1;
        check("reset_w_valid", w_valid, 1'b0);
        check("reset_w_out", w_out, 32'h0);
        check("reset_t_out", t_out, 6'd0);
        check("reset_w_last", w_last, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pin the model against known "abc" schedule words.
        build_model(abc);
        check("model_w16", exp_w[16], 32'h61626380);
        check("model_w17", exp_w[17], 32'h000F0000);
        check("model_w18", exp_w[18], 32'h7DA86405);
        check("model_w19", exp_w[19], 32'h600003C6);
        check("model_w63", exp_w[63], 32'h12B1EDEB);

        run_block(abc, 1'b0, 1'b0, 1'b1, 0);
        check("abc_first_latency", first_cyc - start_cyc, 1);
        check("abc_throughput", last_cyc - first_cyc, 63);

        run_block(zero, 1'b0, 1'b0, 1'b0, 0);
        check("zero_throughput", last_cyc - first_cyc, 63);

        rand_rdy = 1'b1;
        run_block(abc, 1'b1, 1'b0, 1'b0, 0);
        run_block(abc, 1'b1, 1'b1, 1'b0, 0);
        rand_rdy = 1'b0;
        @(posedge clk); #1;

        run_block(abc, 1'b0, 1'b0, 1'b0, 30);
        run_block(abc, 1'b0, 1'b0, 1'b0, 0);

        run_block(blk2, 1'b0, 1'b0, 1'b0, 0);
        run_block(abc, 1'b0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod_msg_sched.md
# mod_msg_sched

SHA-256 message-schedule generator. It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready stream and emits the 64-word schedule W[0..63], one word per transfer, with the round index. It sits directly upstream of the compression-round datapath (Ch/Maj built from MOD_AND32 and friends), which consumes W[t] in round t.

## Interface
- ROUNDS, 64, schedule length; fixed at 64 for SHA-256; other values unsupported.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse in IDLE begins a new block; ignored in any other state.
- WORD_IN  in  32  message word, big-endian word order (W[0] first).
- IN_VALID  in  1  WORD_IN valid.
- IN_READY  out  1  block accepts WORD_IN this cycle.
- W_OUT  out  32  schedule word W[T_OUT].
- T_OUT  out  6  round index of W_OUT.
- W_LAST  out  1  high with W_VALID when T_OUT = 63.
- W_VALID  out  1  W_OUT/T_OUT/W_LAST valid.
- W_READY  in  1  downstream accepts W_OUT this cycle.
- BUSY  out  1  high in LOAD or EXPAND.

## Operation
- States: IDLE, LOAD (t = 0..15), EXPAND (t = 16..63).
- Internal: 6-bit counter t; 16 x 32-bit circular buffer buf; registered output stage (W_OUT, T_OUT, W_LAST, W_VALID).
- Output stage is "free" when !W_VALID || W_READY. Downstream transfer = W_VALID && W_READY.
- IDLE: IN_READY = 0, BUSY = 0. START -> LOAD, t = 0.
- LOAD: IN_READY = free. On IN_VALID && IN_READY: buf[t] <= WORD_IN, output stage <= (WORD_IN, t), t <= t+1. After accepting t = 15 -> EXPAND.
- EXPAND: IN_READY = 0. When free: compute W = σ1(buf[(t+14)%16]) + buf[(t+9)%16] + σ0(buf[(t+1)%16]) + buf[t%16], mod 2^32; buf[t%16] <= W; output stage <= (W, t, t==63); t <= t+1. After loading t = 63 the generator stops; state -> IDLE when that word transfers.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10. All adds 32-bit, carries discarded.
- When not free, buffer, t and output stage hold.
- START while BUSY: ignored, no effect on the block in flight.
- START in the same cycle the W[63] transfer completes: ignored (state still EXPAND at that edge).

## Timing
- Reset (RST_N low, async): state IDLE, t = 0, W_OUT = 0, T_OUT = 0, W_LAST = 0, W_VALID = 0, IN_READY = 0, BUSY = 0; buf cleared to 0. Reset mid-block abandons it; no partial output after release.
- START at edge N -> LOAD from cycle N+1; IN_READY high from cycle N+1 (output stage empty).
- Input-to-output latency: 1 cycle (word accepted at edge k appears on W_OUT after edge k).
- EXPAND word t computed and registered in one cycle; no combinational path from WORD_IN or W_READY to W_OUT.
- Full throughput: with IN_VALID and W_READY held high, 64 words on 64 consecutive cycles, W_VALID first high at cycle N+2, W_LAST at cycle N+65, IDLE at cycle N+66.
- IN_READY depends combinationally on W_READY (through free); W_VALID is registered.

## Test plan
- "abc" padded block (W[0]=0x61626380, W[1..14]=0, W[15]=0x00000018), W_READY=1 -> W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405, W[19]=0x600003C6, W[63]=0x12B1EDEB with W_LAST=1, T_OUT 0..63 in order, 64 consecutive valid cycles.
- All-zero block -> all 64 words 0x00000000; W_LAST only on T_OUT=63; BUSY falls one cycle after last transfer.
- Same "abc" block with W_READY toggled pseudo-randomly and IN_VALID gaps -> identical word sequence, no duplicates or drops, W_OUT stable while W_VALID && !W_READY.
- START pulsed at t=5 and t=40 during a block -> ignored; output sequence unchanged.
- RST_N asserted at t=30 mid-EXPAND -> all outputs reset immediately; subsequent START with "abc" block yields correct full schedule.
- Back-to-back: START in cycle after IDLE re-entry with second block -> second schedule correct, no buffer contamination from first.
